countdown_timer: RTL
====================

// Module: countdown_timer
// PURPOSE
//   Loadable down-counter timer: the count-down counterpart of the up-counter block.
//   Counts from a programmed reload value to zero, then flags terminal count.
//   Then either stops (one-shot) or reloads (periodic).
//   Used as a tick and timeout source next to the free-running counter in lecture designs.
// PARAMETERS
//   N            3    width of count, load_value and the internal reload register
// PORTS
//   clk          in   1    single clock; all state changes on its rising edge
//   reset        in   1    asynchronous, active-low: 0 clears all state immediately
//   load         in   1    capture load_value into the reload register (1-cycle pulse)
//   load_value   in   N    reload value
//   start        in   1    begin counting from the reload value
//   stop         in   1    abort counting and return to IDLE
//   auto_reload  in   1    1 = periodic mode, 0 = one-shot mode
//   count        out  N    current count
//   busy         out  1    high while state is RUN
//   tc           out  1    terminal count: high while RUN and count==0
//   done         out  1    high while state is DONE (one-shot completed)
// BEHAVIOUR
//   Reset (reset==0, async, no clock edge needed):
//   - count=0, reload=0, state=IDLE, busy=0, tc=0, done=0.
//   FSM states: IDLE, RUN, DONE. All outputs are decoded from flops only.
//   - busy = (state==RUN); done = (state==DONE); tc = (state==RUN && count==0).
//   IDLE or DONE:
//   - load only: reload<=load_value, count<=load_value, state<=IDLE (done clears).
//   - start: state<=RUN, count<=reload.
//   - load+start in the same cycle: load_value is used directly for both reload and count.
//   - start with an effective reload of 0: enter RUN with count=0; tc is high that cycle.
//   - stop in DONE: state<=IDLE, count holds.
//   RUN, checked in priority order:
//   - stop: state<=IDLE, count holds its value, no done.
//     tc may still be visible that cycle.
//   - count==0 and auto_reload=1: count<=reload, stay in RUN.
//   - count==0 and auto_reload=0: state<=DONE, count holds 0.
//   - otherwise: count<=count-1.
//   - start in RUN is ignored.
//   - load in RUN updates reload only; it takes effect at the next reload or start.
//   Timing and arithmetic:
//   - Period = reload+1 cycles. tc is high for exactly 1 cycle per period.
//   - Decrement is unsigned N-bit; count never wraps below 0.
//   - reload = 2^N-1 gives a 2^N-cycle period.
//   - start and stop in the same cycle: stop wins in every state.
//   - auto_reload is sampled only at the cycle where count==0.
//   - Reset asserted mid-RUN aborts at once. After release the block stays in IDLE until start.
// STRUCTURE
//   - timer_pkg: typedef enum logic [1:0] {IDLE, RUN, DONE} timer_state_t.
//   - No sub-module: FSM, reload register and decrementer are one always_ff block
//     with async negedge reset, plus continuous assigns for the outputs.
// TESTING (N=3, clk period 10, reset held low until t=7)
//   1. Reset: before t=7 -> count=000, busy=0, tc=0, done=0.
//      Drop reset to 0 mid-RUN -> all outputs 0 before the next edge.
//   2. One-shot: load 5, then start, auto_reload=0 -> count 5,4,3,2,1,0.
//      tc high only in the count==0 cycle; next cycle done=1, busy=0, count=0.
//   3. Periodic: load 2, start, auto_reload=1 -> count 2,1,0,2,1,0...
//      tc pulses every 3 cycles; done stays 0.
//   4. Boundaries:
//      - load 7 -> 8-cycle period.
//      - load 0 + start -> tc high in the first RUN cycle, then DONE.
//      - start+stop together -> IDLE.
//   5. Stop mid-run: stop at count=3 -> IDLE, count holds 3.
//      Next start restarts from reload.
//      A load during RUN does not change count until the next reload.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and defaults for the countdown timer.
package timer_pkg;

  // Default counter width.
  localparam int TIMER_N_DEFAULT = 3;

  // Timer control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_t;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter timer: counts from the reload value to zero, flags
// terminal count, then either stops (one-shot) or reloads (periodic).
module countdown_timer
  import timer_pkg::*;
#(
  parameter int N = TIMER_N_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] load_value,
  input  logic         start,
  input  logic         stop,
  input  logic         auto_reload,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         tc,
  output logic         done
);

  timer_state_t state_q;
  logic [N-1:0] count_q;
  logic [N-1:0] reload_q;

  // FSM, reload register and decrementer in one clocked process.
  // NOTE: every register here is a small flop, so all of them are cleared by
  // the async reset; non-blocking assignments keep each branch reading the
  // pre-edge values of state_q, count_q and reload_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
    end else begin
      // A load always updates the reload register; in RUN the new value is
      // only seen at the next reload or start.
      if (load) reload_q <= load_value;

      case (state_q)
        RUN: begin
          if (stop) begin
            state_q <= IDLE;
          end else if (count_q == '0) begin
            // auto_reload matters only at the terminal-count cycle.
            if (auto_reload) count_q <= reload_q;
            else             state_q <= DONE;
          end else begin
            count_q <= count_q - N'(1);
          end
        end

        IDLE, DONE: begin
          if (stop) begin
            // stop beats start; count holds unless a load arrives with it.
            state_q <= IDLE;
            if (load) count_q <= load_value;
          end else if (start) begin
            // A simultaneous load bypasses the reload register.
            state_q <= RUN;
            count_q <= load ? load_value : reload_q;
          end else if (load) begin
            state_q <= IDLE;
            count_q <= load_value;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from flops only.
  assign count = count_q;
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign tc    = (state_q == RUN) && (count_q == '0);

endmodule
